// File: rtl/mp3_spi_arbiter.sv
// mp3_spi_arbiter: shares the VS10xx serial bus between the SCI command path
// and the SDI byte stream. Drives XCS/XDCS/SCK/SI (SPI mode 0) and gates every
// transfer on DREQ. All pin outputs come straight from flops.
module mp3_spi_arbiter #(
    parameter int CLK_DIV    = 4,   // SCK half-period in clk cycles
    parameter int DATA_BURST = 32   // max SDI bytes per DREQ check
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_DREQ,
    input  logic        i_cmd_req,
    input  logic [7:0]  i_cmd_addr,
    input  logic [15:0] i_cmd_data,
    output logic        o_cmd_ack,
    input  logic        i_dat_valid,
    input  logic [7:0]  i_dat_byte,
    output logic        o_dat_ready,
    output logic        o_XCS,
    output logic        o_XDCS,
    output logic        o_SCK,
    output logic        o_SI,
    output logic        o_busy
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_BURST + 1);

    typedef enum logic [2:0] {IDLE, SCI_SHIFT, SCI_WAIT, SDI_SHIFT, GAP} state_t;
    // Sub-phase inside a shift state: SETUP is the select-low lead-in cycle
    // (for SDI it is also the byte-latch cycle), BITS the bit periods, HOLD the
    // trailing SCK-low cycle before the select rises.
    typedef enum logic [1:0] {PH_SETUP, PH_BITS, PH_HOLD} phase_t;

    state_t         state, nstate;
    phase_t         phase;
    logic [DW-1:0]  div_cnt;
    logic [5:0]     bits_left;
    logic [31:0]    shreg;
    logic [BW-1:0]  burst_cnt;
    logic           sck_q, gap_q, rdy_q, ack_q, xcs_q, xdcs_q, busy_q;

    logic tick, bit_end, last_bit, burst_more;

    assign tick       = (phase == PH_BITS) && (div_cnt == DW'(CLK_DIV - 1));
    assign bit_end    = tick && sck_q;
    assign last_bit   = bit_end && (bits_left == 6'd1);
    // Burst may only continue at a byte boundary and yields to a pending command.
    assign burst_more = i_dat_valid && !i_cmd_req && (burst_cnt < BW'(DATA_BURST));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    // Next-state: commands win over data; nothing starts without DREQ
    always_comb begin
        nstate = state;
        case (state)
            IDLE: begin
                if (i_DREQ && i_cmd_req)        nstate = SCI_SHIFT;
                else if (i_DREQ && i_dat_valid) nstate = SDI_SHIFT;
            end
            SCI_SHIFT: if (phase == PH_HOLD) nstate = SCI_WAIT;
            SCI_WAIT:  if (i_DREQ)           nstate = IDLE;
            SDI_SHIFT: if (phase == PH_HOLD) nstate = GAP;
            GAP:       if (gap_q)            nstate = IDLE;
            default:                         nstate = IDLE;
        endcase
    end

    // Datapath and registered pin outputs; selects/busy/ack are decoded from
    // the next state so they line up with the state register glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= PH_SETUP;
            div_cnt   <= '0;
            bits_left <= '0;
            shreg     <= '0;
            burst_cnt <= '0;
            sck_q     <= 1'b0;
            gap_q     <= 1'b0;
            rdy_q     <= 1'b0;
            ack_q     <= 1'b0;
            xcs_q     <= 1'b1;
            xdcs_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            rdy_q  <= 1'b0;
            ack_q  <= (state == SCI_SHIFT) && (nstate == SCI_WAIT);
            xcs_q  <= (nstate != SCI_SHIFT);
            xdcs_q <= (nstate != SDI_SHIFT);
            busy_q <= (nstate != IDLE);
            gap_q  <= (state == GAP) ? ~gap_q : 1'b0;
            case (state)
                IDLE: begin
                    phase   <= PH_SETUP;
                    sck_q   <= 1'b0;
                    div_cnt <= '0;
                    if (nstate == SCI_SHIFT) begin
                        shreg     <= {8'h02, i_cmd_addr, i_cmd_data};
                        bits_left <= 6'd32;
                    end else if (nstate == SDI_SHIFT) begin
                        burst_cnt <= '0;
                        rdy_q     <= 1'b1;
                        bits_left <= 6'd8;
                    end
                end
                SCI_SHIFT, SDI_SHIFT: begin
                    case (phase)
                        PH_SETUP: begin
                            phase   <= PH_BITS;
                            div_cnt <= '0;
                            sck_q   <= 1'b0;
                            if (state == SDI_SHIFT) begin
                                shreg     <= {i_dat_byte, 24'h0};
                                burst_cnt <= burst_cnt + 1'b1;
                            end
                        end
                        PH_BITS: begin
                            if (tick) begin
                                div_cnt <= '0;
                                sck_q   <= ~sck_q;
                            end else begin
                                div_cnt <= div_cnt + 1'b1;
                            end
                            if (bit_end) begin
                                shreg     <= {shreg[30:0], 1'b0};
                                bits_left <= bits_left - 6'd1;
                            end
                            if (last_bit) begin
                                if (state == SDI_SHIFT && burst_more) begin
                                    phase     <= PH_SETUP;
                                    rdy_q     <= 1'b1;
                                    bits_left <= 6'd8;
                                end else begin
                                    phase <= PH_HOLD;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign o_XCS       = xcs_q;
    assign o_XDCS      = xdcs_q;
    assign o_SCK       = sck_q;
    assign o_SI        = shreg[31];
    assign o_cmd_ack   = ack_q;
    assign o_dat_ready = rdy_q;
    assign o_busy      = busy_q;
endmodule

// File: tb/tb_mp3_spi_arbiter.sv
// Directed bench for mp3_spi_arbiter with CLK_DIV=2, DATA_BURST=32.
module tb_mp3_spi_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_DREQ = 1'b0, i_cmd_req = 1'b0, i_dat_valid = 1'b0;
    logic [7:0]  i_cmd_addr = '0, i_dat_byte = '0;
    logic [15:0] i_cmd_data = '0;
    logic        o_cmd_ack, o_dat_ready, o_XCS, o_XDCS, o_SCK, o_SI, o_busy;

    always #5 clk = ~clk;

    mp3_spi_arbiter #(.CLK_DIV(2), .DATA_BURST(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_DREQ(i_DREQ),
        .i_cmd_req(i_cmd_req), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
        .o_cmd_ack(o_cmd_ack), .i_dat_valid(i_dat_valid), .i_dat_byte(i_dat_byte),
        .o_dat_ready(o_dat_ready), .o_XCS(o_XCS), .o_XDCS(o_XDCS), .o_SCK(o_SCK),
        .o_SI(o_SI), .o_busy(o_busy)
    );

    int n_assert = 0, n_fail = 0;

    // Bus monitor: decodes the pins into words/bytes and counts events
    int          cyc = 0, overlap = 0, sck_bad = 0, ack_rdy = 0;
    int          ack_cnt = 0, rdy_cnt = 0, burst_rdy = 0;
    int          xcs_run = 0, xcs_last_run = 0, sci_bits = 0;
    int          xdcs_hi = 0, xdcs_min_hi = 1000000, xdcs_falls = 0;
    int          xcs_fall_cyc = 0, xdcs_rise_cyc = 0, sdi_nb = 0;
    logic [31:0] sci_word = '0;
    logic [7:0]  sdi_acc = '0;
    logic        sck_d = 1'b0, xcs_d = 1'b1, xdcs_d = 1'b1;
    logic [7:0]  sdi_q[$];
    int          burst_lens[$];

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!o_XCS && !o_XDCS) overlap++;
        if (o_SCK && (o_XCS == o_XDCS)) sck_bad++;
        if (o_cmd_ack && o_dat_ready) ack_rdy++;
        if (!o_XCS && xcs_d) begin xcs_run = 0; sci_bits = 0; xcs_fall_cyc = cyc; end
        if (!o_XCS) xcs_run++;
        else if (!xcs_d) xcs_last_run = xcs_run;
        if (!o_XDCS && xdcs_d) begin
            xdcs_falls++; burst_rdy = 0; sdi_nb = 0;
            if (xdcs_hi < xdcs_min_hi) xdcs_min_hi = xdcs_hi;
        end
        if (o_XDCS && !xdcs_d) begin xdcs_rise_cyc = cyc; burst_lens.push_back(burst_rdy); end
        if (o_XDCS) xdcs_hi++; else xdcs_hi = 0;
        if (o_cmd_ack) ack_cnt++;
        if (o_dat_ready) begin rdy_cnt++; burst_rdy++; end
        if (o_SCK && !sck_d) begin
            if (!o_XCS) begin sci_word = {sci_word[30:0], o_SI}; sci_bits++; end
            if (!o_XDCS) begin
                sdi_acc = {sdi_acc[6:0], o_SI};
                sdi_nb++;
                if (sdi_nb == 8) begin sdi_q.push_back(sdi_acc); sdi_nb = 0; end
            end
        end
        sck_d = o_SCK; xcs_d = o_XCS; xdcs_d = o_XDCS;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle step; after a latched byte the next SDI byte value is presented
    logic rdy_prev = 1'b0;
    task automatic tick();
        @(negedge clk);
        #1;
        if (rdy_prev) i_dat_byte = i_dat_byte + 8'd1;
        rdy_prev = o_dat_ready;
    endtask

    task automatic wait_ack(input int budget, input string tag);
        int  a0 = ack_cnt;
        bit  got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = (ack_cnt != a0);
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = !o_busy;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    int a0, r0, f0, q0, l0;
    bit done;

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_xcs", o_XCS, 1); chk("rst_xdcs", o_XDCS, 1); chk("rst_sck", o_SCK, 0);
        chk("rst_si", o_SI, 0); chk("rst_ack", o_cmd_ack, 0); chk("rst_rdy", o_dat_ready, 0);
        chk("rst_busy", o_busy, 0);
        rst_n = 1'b1;
        tick();

        // Single SCI write
        i_DREQ = 1; i_cmd_addr = 8'h0B; i_cmd_data = 16'h2020; i_cmd_req = 1;
        a0 = ack_cnt; f0 = xdcs_falls;
        tick();
        chk("sci_start_xcs", o_XCS, 0); chk("sci_start_busy", o_busy, 1);
        wait_ack(200, "sci1_ack_seen");
        i_cmd_req = 0;
        chk("sci1_word", sci_word, 32'h020B2020); chk("sci1_bits", sci_bits, 32);
        chk("sci1_xcs_low", xcs_last_run, 130); chk("sci1_xcs_at_ack", o_XCS, 1);
        repeat (4) tick();
        chk("sci1_one_ack", ack_cnt - a0, 1); chk("sci1_no_xdcs", xdcs_falls - f0, 0);
        chk("sci1_idle", o_busy, 0);

        // Two full SDI bursts carrying 0x00..0x3F
        i_dat_byte = 8'h00; i_dat_valid = 1;
        r0 = rdy_cnt; f0 = xdcs_falls; q0 = sdi_q.size(); l0 = burst_lens.size(); done = 0;
        for (int i = 0; i < 2500 && !done; i++) begin
            tick();
            if (i_dat_byte == 8'h40) i_dat_valid = 0;
            done = !i_dat_valid && !o_busy;
        end
        chk("burst_done", 32'(done), 1);
        chk("burst_rdy_total", rdy_cnt - r0, 64); chk("burst_count", xdcs_falls - f0, 2);
        chk("burst_bytes_rx", sdi_q.size() - q0, 64);
        if (burst_lens.size() >= l0 + 2) begin
            chk("burst1_len", burst_lens[l0], 32); chk("burst2_len", burst_lens[l0+1], 32);
        end else chk("burst_lens_seen", burst_lens.size() - l0, 2);
        if (sdi_q.size() >= q0 + 64)
            for (int i = 0; i < 64; i++) chk($sformatf("burst_byte%0d", i), sdi_q[q0+i], i);

        // Command and data together: SCI first, wait on DREQ, then SDI
        i_cmd_addr = 8'h03; i_cmd_data = 16'h1234; i_dat_byte = 8'hA5;
        i_cmd_req = 1; i_dat_valid = 1;
        r0 = rdy_cnt; f0 = xdcs_falls; q0 = sdi_q.size();
        wait_ack(200, "prio_ack_seen");
        i_cmd_req = 0; i_DREQ = 0;
        chk("prio_no_sdi_yet", xdcs_falls - f0, 0); chk("prio_word", sci_word, 32'h02031234);
        repeat (5) tick();
        chk("prio_wait_busy", o_busy, 1); chk("prio_wait_xdcs", o_XDCS, 1);
        chk("prio_wait_rdy", rdy_cnt - r0, 0);
        i_DREQ = 1; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin tick(); done = (rdy_cnt != r0); end
        chk("prio_sdi_start", 32'(done), 1);
        tick();
        i_dat_valid = 0;
        wait_idle(100, "prio_idle");
        chk("prio_rdy", rdy_cnt - r0, 1);
        if (sdi_q.size() > q0) chk("prio_byte", sdi_q[q0], 8'hA5);
        else chk("prio_byte_rx", sdi_q.size() - q0, 1);

        // Command raised mid byte 3 preempts at the byte boundary
        i_dat_byte = 8'h50; i_dat_valid = 1;
        r0 = rdy_cnt; q0 = sdi_q.size(); l0 = burst_lens.size(); done = 0;
        for (int i = 0; i < 200 && !done; i++) begin tick(); done = (rdy_cnt - r0 == 3); end
        chk("pre_three_bytes", 32'(done), 1);
        repeat (4) tick();
        i_cmd_addr = 8'h0B; i_cmd_data = 16'h0055; i_cmd_req = 1;
        wait_ack(300, "pre_ack_seen");
        i_cmd_req = 0; i_dat_valid = 0;
        wait_idle(50, "pre_idle");
        chk("pre_rdy", rdy_cnt - r0, 3);
        if (burst_lens.size() > l0) chk("pre_burst_len", burst_lens[l0], 3);
        else chk("pre_burst_seen", burst_lens.size() - l0, 1);
        chk("pre_word", sci_word, 32'h020B0055);
        chk("pre_gap", xcs_fall_cyc - xdcs_rise_cyc, 3);
        if (sdi_q.size() >= q0 + 3) chk("pre_byte3", sdi_q[q0+2], 8'h52);
        chk("pre_overlap", overlap, 0);

        // DREQ low blocks everything; rising DREQ starts the command next cycle
        i_DREQ = 0; i_cmd_addr = 8'h0A; i_cmd_data = 16'h8001; i_cmd_req = 1;
        i_dat_byte = 8'h77; i_dat_valid = 1; r0 = rdy_cnt;
        repeat (10) tick();
        chk("dreq0_busy", o_busy, 0); chk("dreq0_xcs", o_XCS, 1); chk("dreq0_xdcs", o_XDCS, 1);
        chk("dreq0_rdy", rdy_cnt - r0, 0);
        i_DREQ = 1;
        tick();
        chk("dreq1_xcs", o_XCS, 0); chk("dreq1_busy", o_busy, 1);
        wait_ack(200, "dreq1_ack_seen");
        i_cmd_req = 0; i_dat_valid = 0;
        chk("dreq1_word", sci_word, 32'h020A8001);
        wait_idle(50, "dreq1_idle");
        chk("dreq1_no_sdi", rdy_cnt - r0, 0);

        // Reset at bit 10 aborts; the held request is retransmitted in full
        i_cmd_addr = 8'h0B; i_cmd_data = 16'hBEEF; i_cmd_req = 1; a0 = ack_cnt; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin tick(); done = !o_XCS && (sci_bits == 10); end
        chk("rst_mid_reached", 32'(done), 1);
        rst_n = 0;
        #1;
        chk("rmid_xcs", o_XCS, 1); chk("rmid_sck", o_SCK, 0); chk("rmid_si", o_SI, 0);
        chk("rmid_busy", o_busy, 0); chk("rmid_xdcs", o_XDCS, 1);
        repeat (2) tick();
        chk("rmid_no_ack", ack_cnt - a0, 0);
        rst_n = 1;
        wait_ack(300, "rmid_ack_seen");
        i_cmd_req = 0;
        chk("rmid_word", sci_word, 32'h020BBEEF); chk("rmid_bits", sci_bits, 32);
        chk("rmid_xcs_low", xcs_last_run, 130); chk("rmid_one_ack", ack_cnt - a0, 1);
        wait_idle(50, "rmid_idle");

        // Whole-run invariants
        chk("inv_overlap", overlap, 0); chk("inv_sck", sck_bad, 0);
        chk("inv_ack_rdy", ack_rdy, 0); chk("inv_xdcs_gap", 32'(xdcs_min_hi >= 2), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
